// File: rtl/kbd_ascii_decoder_if.sv
// Bus between a PS/2 Set-2 scan-byte source, the ASCII decoder and the
// downstream consumer of decoded characters. The master side drives scan bytes
// and the consumer ready. The slave side is the decoder itself.
interface kbd_ascii_decoder_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    scan_code;
    logic          scan_valid;
    logic [7:0]    ascii_code;
    logic          ascii_valid;
    logic          ascii_ready;
    logic          shift_active;
    logic          caps_lock;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    modport master (
        output scan_code,
        output scan_valid,
        output ascii_ready,
        input  ascii_code,
        input  ascii_valid,
        input  shift_active,
        input  caps_lock,
        input  fifo_count,
        input  overflow
    );

    modport slave (
        input  scan_code,
        input  scan_valid,
        input  ascii_ready,
        output ascii_code,
        output ascii_valid,
        output shift_active,
        output caps_lock,
        output fifo_count,
        output overflow
    );
endinterface

// File: rtl/kbd_ascii_decoder.sv
// PS/2 Set-2 scan-code to ASCII decoder. It has the following parts:
// - A prefix FSM that tracks the E0 and F0 prefixes.
// - Shift and caps-lock tracking.
// - A US-layout mapping table.
// - A registered push stage.
// - A first-word-fall-through output FIFO whose outputs are all registered.
module kbd_ascii_decoder #(
    parameter int         FIFO_DEPTH    = 8,
    parameter bit         DROP_UNMAPPED = 1'b0,
    parameter logic [7:0] ERR_CODE      = 8'h2A
) (
    input logic               clk,
    input logic               resetn,
    kbd_ascii_decoder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // Letter helper: the flag selects the upper-case form.
    function automatic logic [8:0] letter_f(input logic [7:0] lower, input logic up);
        return {1'b1, (up ? (lower - 8'h20) : lower)};
    endfunction

    // Symbol helper: shift alone selects the shifted glyph.
    function automatic logic [8:0] sym_f(input logic [7:0] base, input logic [7:0] shifted,
                                         input logic sh);
        return {1'b1, (sh ? shifted : base)};
    endfunction

    // Returns {hit, ascii} for a make code. Extended codes hit only on navigation keys.
    function automatic logic [8:0] map_make(input logic [7:0] code, input logic ext,
                                            input logic sh, input logic caps);
        logic [8:0] r;
        logic       up;
        up = sh ^ caps;
        case (code)
            8'h75:   r = {1'b1, 8'h11};
            8'h6B:   r = {1'b1, 8'h12};
            8'h72:   r = {1'b1, 8'h13};
            8'h74:   r = {1'b1, 8'h14};
            8'h6C:   r = {1'b1, 8'h0D};
            8'h7D:   r = {1'b1, 8'h02};
            8'h7A:   r = {1'b1, 8'h03};
            8'h69:   r = {1'b1, 8'h17};
            8'h71:   r = {1'b1, 8'h7F};
            8'h70:   r = {1'b1, 8'h1A};
            default: r = 9'h000;
        endcase
        if (!ext && !r[8]) begin
            case (code)
                8'h1C:   r = letter_f(8'h61, up);
                8'h32:   r = letter_f(8'h62, up);
                8'h21:   r = letter_f(8'h63, up);
                8'h23:   r = letter_f(8'h64, up);
                8'h24:   r = letter_f(8'h65, up);
                8'h2B:   r = letter_f(8'h66, up);
                8'h34:   r = letter_f(8'h67, up);
                8'h33:   r = letter_f(8'h68, up);
                8'h43:   r = letter_f(8'h69, up);
                8'h3B:   r = letter_f(8'h6A, up);
                8'h42:   r = letter_f(8'h6B, up);
                8'h4B:   r = letter_f(8'h6C, up);
                8'h3A:   r = letter_f(8'h6D, up);
                8'h31:   r = letter_f(8'h6E, up);
                8'h44:   r = letter_f(8'h6F, up);
                8'h4D:   r = letter_f(8'h70, up);
                8'h15:   r = letter_f(8'h71, up);
                8'h2D:   r = letter_f(8'h72, up);
                8'h1B:   r = letter_f(8'h73, up);
                8'h2C:   r = letter_f(8'h74, up);
                8'h3C:   r = letter_f(8'h75, up);
                8'h2A:   r = letter_f(8'h76, up);
                8'h1D:   r = letter_f(8'h77, up);
                8'h22:   r = letter_f(8'h78, up);
                8'h35:   r = letter_f(8'h79, up);
                8'h1A:   r = letter_f(8'h7A, up);
                8'h16:   r = sym_f(8'h31, 8'h21, sh);
                8'h1E:   r = sym_f(8'h32, 8'h40, sh);
                8'h26:   r = sym_f(8'h33, 8'h23, sh);
                8'h25:   r = sym_f(8'h34, 8'h24, sh);
                8'h2E:   r = sym_f(8'h35, 8'h25, sh);
                8'h36:   r = sym_f(8'h36, 8'h5E, sh);
                8'h3D:   r = sym_f(8'h37, 8'h26, sh);
                8'h3E:   r = sym_f(8'h38, 8'h2A, sh);
                8'h46:   r = sym_f(8'h39, 8'h28, sh);
                8'h45:   r = sym_f(8'h30, 8'h29, sh);
                8'h0E:   r = sym_f(8'h60, 8'h7E, sh);
                8'h4E:   r = sym_f(8'h2D, 8'h5F, sh);
                8'h55:   r = sym_f(8'h3D, 8'h2B, sh);
                8'h54:   r = sym_f(8'h5B, 8'h7B, sh);
                8'h5B:   r = sym_f(8'h5D, 8'h7D, sh);
                8'h5D:   r = sym_f(8'h5C, 8'h7C, sh);
                8'h4C:   r = sym_f(8'h3B, 8'h3A, sh);
                8'h52:   r = sym_f(8'h27, 8'h22, sh);
                8'h41:   r = sym_f(8'h2C, 8'h3C, sh);
                8'h49:   r = sym_f(8'h2E, 8'h3E, sh);
                8'h4A:   r = sym_f(8'h2F, 8'h3F, sh);
                8'h29:   r = {1'b1, 8'h20};
                8'h5A:   r = {1'b1, 8'h0A};
                8'h66:   r = {1'b1, 8'h08};
                8'h0D:   r = {1'b1, 8'h09};
                default: r = 9'h000;
            endcase
        end else begin
            r = r;
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic            shift_l_q, shift_l_d;
    logic            shift_r_q, shift_r_d;
    logic            caps_held_q, caps_held_d;
    logic            caps_lock_q, caps_lock_d;
    logic            shift_active_q;
    logic            push_req_q, push_req_d;
    logic [7:0]      push_byte_q, push_byte_d;
    logic            make_s, brk_s, ext_s;
    logic [8:0]      map_s;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ascii_valid_q;
    logic [7:0]      ascii_code_q, head_d;
    logic            overflow_q, overflow_d;
    logic            pop_s, full_s, push_ok_s;

    // Prefix decoding, modifier tracking and translation of a make code into a push request.
    always_comb begin
        state_d     = state_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        caps_held_d = caps_held_q;
        caps_lock_d = caps_lock_q;
        push_req_d  = 1'b0;
        push_byte_d = push_byte_q;
        make_s      = 1'b0;
        brk_s       = 1'b0;
        ext_s       = (state_q == ST_EXT);
        map_s       = map_make(bus.scan_code, ext_s, shift_active_q, caps_lock_q);

        if (bus.scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.scan_code == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (bus.scan_code == 8'hF0) begin
                        state_d = ST_BRK;
                    end else begin
                        make_s = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (bus.scan_code == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        make_s  = 1'b1;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    brk_s   = 1'b1;
                end
                ST_EXT_BRK: begin
                    // Extended breaks (including fake shifts) carry no information we need.
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        if (make_s) begin
            if (!ext_s && bus.scan_code == 8'h12) begin
                shift_l_d = 1'b1;
            end else if (!ext_s && bus.scan_code == 8'h59) begin
                shift_r_d = 1'b1;
            end else if (!ext_s && bus.scan_code == 8'h58) begin
                // Typematic repeats arrive while held and must not re-toggle.
                caps_lock_d = caps_held_q ? caps_lock_q : ~caps_lock_q;
                caps_held_d = 1'b1;
            end else if (ext_s && (bus.scan_code == 8'h12 || bus.scan_code == 8'h59)) begin
                push_req_d = 1'b0;
            end else if (map_s[8]) begin
                push_req_d  = 1'b1;
                push_byte_d = map_s[7:0];
            end else if (!DROP_UNMAPPED) begin
                push_req_d  = 1'b1;
                push_byte_d = ERR_CODE;
            end else begin
                push_req_d = 1'b0;
            end
        end else if (brk_s) begin
            if (bus.scan_code == 8'h12) begin
                shift_l_d = 1'b0;
            end else if (bus.scan_code == 8'h59) begin
                shift_r_d = 1'b0;
            end else if (bus.scan_code == 8'h58) begin
                caps_held_d = 1'b0;
            end else begin
                push_req_d = 1'b0;
            end
        end else begin
            push_req_d = 1'b0;
        end
    end

    // Prefix FSM, modifier state and push-stage registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            shift_l_q      <= 1'b0;
            shift_r_q      <= 1'b0;
            caps_held_q    <= 1'b0;
            caps_lock_q    <= 1'b0;
            shift_active_q <= 1'b0;
            push_req_q     <= 1'b0;
            push_byte_q    <= 8'h00;
        end else begin
            state_q        <= state_d;
            shift_l_q      <= shift_l_d;
            shift_r_q      <= shift_r_d;
            caps_held_q    <= caps_held_d;
            caps_lock_q    <= caps_lock_d;
            shift_active_q <= shift_l_d | shift_r_d;
            push_req_q     <= push_req_d;
            push_byte_q    <= push_byte_d;
        end
    end

    // FIFO control. A pop frees the slot, so push and pop may coincide when full.
    always_comb begin
        pop_s      = ascii_valid_q & bus.ascii_ready;
        full_s     = (count_q == DEPTH_C);
        push_ok_s  = push_req_q & (~full_s | pop_s);
        overflow_d = push_req_q & full_s & ~pop_s;
        wr_ptr_d   = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // The next head is the incoming byte when it lands exactly at the new read slot.
        if (count_d == CNT_ZERO) begin
            head_d = 8'h00;
        end else if (push_ok_s && (rd_ptr_d == wr_ptr_q)) begin
            head_d = push_byte_q;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_byte_q;
        end
    end

    // FIFO pointers, occupancy and registered head/status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= CNT_ZERO;
            ascii_valid_q <= 1'b0;
            ascii_code_q  <= 8'h00;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ascii_valid_q <= (count_d != CNT_ZERO);
            ascii_code_q  <= head_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.ascii_code   = ascii_code_q;
    assign bus.ascii_valid  = ascii_valid_q;
    assign bus.shift_active = shift_active_q;
    assign bus.caps_lock    = caps_lock_q;
    assign bus.fifo_count   = count_q;
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_kbd_ascii_decoder.sv
// Directed testbench for kbd_ascii_decoder with hand-computed expected bytes.
module tb_kbd_ascii_decoder;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ovf_cnt = 0;
    logic [7:0] got [$];

    kbd_ascii_decoder_if #(.FIFO_DEPTH(DEPTH)) bus ();

    kbd_ascii_decoder #(
        .FIFO_DEPTH(DEPTH),
        .DROP_UNMAPPED(1'b0),
        .ERR_CODE(8'h2A)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Record every popped byte and every overflow pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.ascii_valid === 1'b1 && bus.ascii_ready === 1'b1) got.push_back(bus.ascii_code);
        if (bus.overflow === 1'b1) ovf_cnt++;
    end

    task automatic send(input logic [7:0] b);
        bus.scan_code  = b;
        bus.scan_valid = 1'b1;
        @(posedge clk); #1;
        bus.scan_valid = 1'b0;
        bus.scan_code  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.scan_code  = 8'h1C;
        bus.scan_valid = 1'b1;
        bus.ascii_ready = 1'b1;
        resetn = 1'b0;
        idle(3);
        bus.scan_valid = 1'b0;
        checks++; if (bus.ascii_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.ascii_valid); end
        checks++; if (bus.fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.ascii_code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h expected 00", bus.ascii_code); end
        checks++; if (bus.shift_active !== 1'b0 || bus.caps_lock !== 1'b0) begin errors++; $display("FAIL reset_mods: got %b%b expected 00", bus.shift_active, bus.caps_lock); end
        resetn = 1'b1;
        got.delete();
        idle(3);
        checks++; if (bus.ascii_valid !== 1'b0 || got.size() != 0) begin errors++; $display("FAIL reset_scan_ignored: got valid=%b n=%0d expected 0 0", bus.ascii_valid, got.size()); end
    endtask

    task automatic test_latency();
        bus.ascii_ready = 1'b0;
        got.delete();
        send(8'h1C);
        checks++; if (bus.ascii_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", bus.ascii_valid); end
        idle(1);
        checks++; if (bus.ascii_valid !== 1'b1 || bus.ascii_code !== 8'h61) begin errors++; $display("FAIL latency_head: got %b/%h expected 1/61", bus.ascii_valid, bus.ascii_code); end
        checks++; if (bus.fifo_count !== 4'd1) begin errors++; $display("FAIL latency_count: got %0d expected 1", bus.fifo_count); end
        bus.ascii_ready = 1'b1;
        idle(3);
        checks++; if (bus.fifo_count !== 4'd0 || got.size() != 1) begin errors++; $display("FAIL latency_drain: got %0d/%0d expected 0/1", bus.fifo_count, got.size()); end
    endtask

    task automatic test_basic();
        logic [7:0] exp [$];
        exp = '{8'h61, 8'h41};
        got.delete();
        send(8'h1C);
        send(8'h12);
        checks++; if (bus.shift_active !== 1'b1) begin errors++; $display("FAIL basic_shift_on: got %b expected 1", bus.shift_active); end
        send(8'h1C); send(8'hF0); send(8'h12);
        send(8'hF0); send(8'h1C);
        idle(4);
        checks++; if (bus.shift_active !== 1'b0) begin errors++; $display("FAIL basic_shift_off: got %b expected 0", bus.shift_active); end
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL basic_n: got %0d expected %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
    endtask

    task automatic test_caps();
        logic [7:0] exp [$];
        exp = '{8'h41, 8'h61, 8'h21};
        got.delete();
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58);
        checks++; if (bus.caps_lock !== 1'b1) begin errors++; $display("FAIL caps_on: got %b expected 1", bus.caps_lock); end
        send(8'h1C);
        send(8'h12); send(8'h1C);
        send(8'h16);
        send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58);
        idle(4);
        checks++; if (bus.caps_lock !== 1'b0) begin errors++; $display("FAIL caps_off: got %b expected 0", bus.caps_lock); end
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL caps_n: got %0d expected %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL caps_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
    endtask

    task automatic test_ext();
        logic [7:0] exp [$];
        exp = '{8'h11, 8'h61, 8'h12};
        got.delete();
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hE0); send(8'h12);
        checks++; if (bus.shift_active !== 1'b0) begin errors++; $display("FAIL ext_fake_shift: got %b expected 0", bus.shift_active); end
        send(8'h1C);
        send(8'hE0); send(8'h6B);
        send(8'hF0); send(8'h1C);
        idle(4);
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL ext_n: got %0d expected %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL ext_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
    endtask

    task automatic test_mapping();
        logic [7:0] codes [$];
        logic [7:0] exp [$];
        codes = '{8'h4A, 8'h29, 8'h5A, 8'h66, 8'h0D, 8'h75, 8'h70,
                  8'h12, 8'h4A, 8'h1E, 8'h0E, 8'h52, 8'h1A, 8'hF0, 8'h12,
                  8'h58, 8'hF0, 8'h58, 8'h1E, 8'h4A, 8'h1A, 8'h58, 8'hF0, 8'h58};
        exp = '{8'h2F, 8'h20, 8'h0A, 8'h08, 8'h09, 8'h11, 8'h1A,
                8'h3F, 8'h40, 8'h7E, 8'h22, 8'h5A, 8'h32, 8'h2F, 8'h5A};
        got.delete();
        foreach (codes[k]) send(codes[k]);
        idle(4);
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL map_n: got %0d expected %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL map_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [$];
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
        bus.ascii_ready = 1'b0;
        got.delete();
        ovf_cnt = 0;
        foreach (codes[k]) send(codes[k]);
        idle(2);
        checks++; if (bus.fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", bus.fifo_count); end
        checks++; if (bus.ascii_code !== 8'h61) begin errors++; $display("FAIL ovf_head: got %h expected 61", bus.ascii_code); end
        checks++; if (ovf_cnt != 1) begin errors++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_cnt); end
        bus.ascii_ready = 1'b1;
        idle(12);
        checks++; if (got.size() != DEPTH) begin errors++; $display("FAIL ovf_n: got %0d expected %0d", got.size(), DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== 8'(8'h61 + i)) begin errors++; $display("FAIL ovf_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, 8'(8'h61 + i)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [$];
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33};
        bus.ascii_ready = 1'b0;
        got.delete();
        foreach (codes[k]) send(codes[k]);
        idle(2);
        checks++; if (bus.fifo_count !== 4'd8) begin errors++; $display("FAIL b2b_full: got %0d expected 8", bus.fifo_count); end
        ovf_cnt = 0;
        bus.scan_code  = 8'h43;
        bus.scan_valid = 1'b1;
        @(posedge clk); #1;
        bus.scan_valid  = 1'b0;
        bus.ascii_ready = 1'b1;
        @(posedge clk); #1;
        bus.ascii_ready = 1'b0;
        checks++; if (bus.fifo_count !== 4'd8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", bus.fifo_count); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", bus.overflow); end
        checks++; if (bus.ascii_code !== 8'h62) begin errors++; $display("FAIL b2b_head: got %h expected 62", bus.ascii_code); end
        bus.ascii_ready = 1'b1;
        idle(12);
        checks++; if (ovf_cnt != 0) begin errors++; $display("FAIL b2b_pulses: got %0d expected 0", ovf_cnt); end
        checks++; if (got.size() != 9) begin errors++; $display("FAIL b2b_n: got %0d expected 9", got.size()); end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== 8'(8'h61 + i)) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, 8'(8'h61 + i)); end
        end
    endtask

    task automatic test_reset_prefix();
        logic [7:0] exp [$];
        exp = '{8'h11, 8'h2A, 8'h2A, 8'h2A};
        send(8'h58); send(8'hF0); send(8'h58);
        checks++; if (bus.caps_lock !== 1'b1) begin errors++; $display("FAIL rstpfx_caps_set: got %b expected 1", bus.caps_lock); end
        send(8'hE0); send(8'hF0);
        got.delete();
        resetn = 1'b0;
        bus.scan_code  = 8'h75;
        bus.scan_valid = 1'b1;
        idle(1);
        bus.scan_valid = 1'b0;
        resetn = 1'b1;
        checks++; if (bus.caps_lock !== 1'b0) begin errors++; $display("FAIL rstpfx_caps_clr: got %b expected 0", bus.caps_lock); end
        send(8'h75); send(8'h07); send(8'hE1); send(8'h00);
        idle(4);
        checks++; if (got.size() != exp.size()) begin errors++; $display("FAIL rstpfx_n: got %0d expected %0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin errors++; $display("FAIL rstpfx_byte%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]); end
        end
    endtask

    initial begin
        bus.scan_code   = 8'h00;
        bus.scan_valid  = 1'b0;
        bus.ascii_ready = 1'b1;
        test_reset();
        test_latency();
        test_basic();
        test_caps();
        test_ext();
        test_mapping();
        test_overflow();
        test_back_to_back();
        test_reset_prefix();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
